// File: rtl/fp_pkg.sv
// Shared single-precision float types and integer limits for fp_adder and fp_to_int32.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_BIAS   = 127;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    CVT_IDLE  = 2'd0,
    CVT_SHIFT = 2'd1,
    CVT_ROUND = 2'd2,
    CVT_DONE  = 2'd3
  } cvt_state_e;

  typedef enum logic [1:0] {
    CLS_NUM = 2'd0,
    CLS_NAN = 2'd1,
    CLS_SAT = 2'd2
  } cvt_cls_e;

  function automatic logic [5:0] min_u6(input logic [5:0] a, input logic [5:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even, sign application and saturation for fp_to_int32.
// Flag outputs exist only when FP_TO_INT32_FLAGS_EN is defined.
module fp_rne_round
  import fp_pkg::*;
(
  input  logic        sign_i,
  input  cvt_cls_e    cls_i,
  input  logic [31:0] int_i,
  input  logic        guard_i,
  input  logic        lsb_i,
  input  logic        rs_i,
`ifdef FP_TO_INT32_FLAGS_EN
  output logic        invalid_o,
  output logic        inexact_o,
`endif
  output logic [31:0] result_o
);

  logic [31:0] mag_s;
  logic [31:0] signed_s;

  // Round the magnitude, negate for negative inputs, then override with saturation values.
  always_comb begin
    mag_s    = int_i + {31'd0, guard_i & (lsb_i | rs_i)};
    signed_s = sign_i ? (~mag_s + 32'd1) : mag_s;
    case (cls_i)
      CLS_NAN: result_o = INT_MIN;
      CLS_SAT: result_o = sign_i ? INT_MIN : INT_MAX;
      default: result_o = signed_s;
    endcase
  end

`ifdef FP_TO_INT32_FLAGS_EN
  // Specials never report inexact; exact -2^31 is classified as a normal number.
  always_comb begin
    invalid_o = (cls_i != CLS_NUM);
    inexact_o = (cls_i == CLS_NUM) && (guard_i || rs_i);
  end
`endif

endmodule

// File: rtl/fp_to_int32.sv
// Iterative IEEE-754 single to int32 converter with RNE rounding and ready/valid handshakes.
// Optional flag_invalid/flag_inexact outputs are enabled by defining FP_TO_INT32_FLAGS_EN.
module fp_to_int32
  import fp_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_f,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef FP_TO_INT32_FLAGS_EN
  output logic        flag_invalid,
  output logic        flag_inexact,
`endif
  output logic [31:0] out_i
);

  localparam logic [5:0] STEP_U6   = 6'(STEP);
  localparam logic [7:0] EXP_UNITY = 8'(FP_BIAS + FP_FRAC_W);
  localparam logic [7:0] EXP_LAST  = 8'(FP_BIAS + FP_FRAC_W + 7);
  localparam logic [7:0] EXP_MIN31 = 8'(FP_BIAS + 31);

  cvt_state_e  state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] out_q;
  logic        sign_q;
  logic        left_q;
  cvt_cls_e    cls_q;
  logic [5:0]  rem_q;
  logic [63:0] w_q;
  logic        sticky_q;

  fp32_t       f_s;
  logic [7:0]  rsh_s;
  logic        exact_min_s;
  cvt_cls_e    acc_cls_d;
  logic        acc_left_d;
  logic [5:0]  acc_rem_d;

  logic [5:0]  amt_s;
  logic        drop_s;
  logic [63:0] w_step_s;

  logic [31:0] rnd_res_s;
`ifdef FP_TO_INT32_FLAGS_EN
  logic        rnd_inv_s;
  logic        rnd_inx_s;
  logic        flag_invalid_q;
  logic        flag_inexact_q;
`endif

  // Classify the incoming float into special/left/right and the shift distance.
  always_comb begin
    f_s         = fp32_t'(in_f);
    rsh_s       = EXP_UNITY - f_s.exp;
    exact_min_s = f_s.sign && (f_s.exp == EXP_MIN31) && (f_s.frac == 23'd0);
    acc_cls_d   = CLS_NUM;
    acc_left_d  = 1'b0;
    acc_rem_d   = 6'd0;
    if (f_s.exp == FP_EXP_MAX) begin
      acc_cls_d = (f_s.frac != 23'd0) ? CLS_NAN : CLS_SAT;
    end else if ((f_s.exp > EXP_LAST) && !exact_min_s) begin
      acc_cls_d = CLS_SAT;
    end else if (f_s.exp >= EXP_UNITY) begin
      acc_left_d = 1'b1;
      acc_rem_d  = 6'(f_s.exp - EXP_UNITY);
    end else if ((f_s.exp == 8'd0) || (rsh_s > 8'd33)) begin
      acc_rem_d = 6'd33;
    end else begin
      acc_rem_d = rsh_s[5:0];
    end
  end

  // One shifter step; bits falling off the bottom on right shifts feed sticky.
  always_comb begin
    amt_s  = min_u6(rem_q, STEP_U6);
    drop_s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drop_s = drop_s | (w_q[i] & (6'(i) < amt_s));
    end
    w_step_s = left_q ? (w_q << amt_s) : (w_q >> amt_s);
  end

  fp_rne_round u_round (
    .sign_i    (sign_q),
    .cls_i     (cls_q),
    .int_i     (w_q[63:32]),
    .guard_i   (w_q[31]),
    .lsb_i     (w_q[32]),
    .rs_i      ((|w_q[30:0]) | sticky_q),
`ifdef FP_TO_INT32_FLAGS_EN
    .invalid_o (rnd_inv_s),
    .inexact_o (rnd_inx_s),
`endif
    .result_o  (rnd_res_s)
  );

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CVT_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= 32'd0;
      sign_q      <= 1'b0;
      left_q      <= 1'b0;
      cls_q       <= CLS_NUM;
      rem_q       <= 6'd0;
      w_q         <= 64'd0;
      sticky_q    <= 1'b0;
`ifdef FP_TO_INT32_FLAGS_EN
      flag_invalid_q <= 1'b0;
      flag_inexact_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        CVT_IDLE: begin
          if (in_valid) begin
            sign_q     <= f_s.sign;
            left_q     <= acc_left_d;
            cls_q      <= acc_cls_d;
            rem_q      <= acc_rem_d;
            w_q        <= {8'd0, (f_s.exp != 8'd0), f_s.frac, 32'd0};
            sticky_q   <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= CVT_SHIFT;
          end else begin
            state_q <= CVT_IDLE;
          end
        end
        CVT_SHIFT: begin
          if (rem_q == 6'd0) begin
            state_q <= CVT_ROUND;
          end else begin
            w_q      <= w_step_s;
            rem_q    <= rem_q - amt_s;
            sticky_q <= sticky_q | (drop_s & ~left_q);
          end
        end
        CVT_ROUND: begin
          out_q       <= rnd_res_s;
          out_valid_q <= 1'b1;
`ifdef FP_TO_INT32_FLAGS_EN
          flag_invalid_q <= rnd_inv_s;
          flag_inexact_q <= rnd_inx_s;
`endif
          state_q     <= CVT_DONE;
        end
        CVT_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= CVT_IDLE;
          end else begin
            state_q <= CVT_DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= CVT_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_i     = out_q;
`ifdef FP_TO_INT32_FLAGS_EN
  assign flag_invalid = flag_invalid_q;
  assign flag_inexact = flag_inexact_q;
`endif

endmodule

// File: tb/tb_fp_to_int32.sv
// Table-driven scoreboard bench for fp_to_int32 (STEP=1): values, latency, backpressure, reset abort.
module tb_fp_to_int32;

  localparam int unsigned STEP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_f;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_i;
`ifdef FP_TO_INT32_FLAGS_EN
  logic        flag_invalid;
  logic        flag_inexact;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] f;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        inv;
    logic        inx;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[21];

  fp_to_int32 #(.STEP(STEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_f         (in_f),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef FP_TO_INT32_FLAGS_EN
    .flag_invalid (flag_invalid),
    .flag_inexact (flag_inexact),
`endif
    .out_i        (out_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    exp_t e;
    logic [31:0] held;
    check($sformatf("v%0d_in_ready_idle", idx), {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_f     = v.f;
    sb_q.push_back('{res: v.res, inv: v.inv, inx: v.inx});
    @(negedge clk);
    in_valid = 1'b0;
    in_f     = $urandom;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d_sb_nonempty", idx), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("v%0d_out_i", idx), out_i, e.res);
`ifdef FP_TO_INT32_FLAGS_EN
        check($sformatf("v%0d_invalid", idx), {31'd0, flag_invalid}, {31'd0, e.inv});
        check($sformatf("v%0d_inexact", idx), {31'd0, flag_inexact}, {31'd0, e.inx});
`endif
      end
      held = out_i;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        check($sformatf("v%0d_hold_valid", idx), {31'd0, out_valid}, 32'd1);
        check($sformatf("v%0d_hold_out", idx), out_i, held);
        check($sformatf("v%0d_hold_ready", idx), {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check($sformatf("v%0d_ready_after", idx), {31'd0, in_ready}, 32'd1);
      check($sformatf("v%0d_valid_after", idx), {31'd0, out_valid}, 32'd0);
    end else begin
      sb_q.delete();
    end
  endtask

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h00000001, 1'b0, 1'b0, 25, 10};
    vecs[1]  = '{32'h40200000, 32'h00000002, 1'b0, 1'b1, 24, 0};
    vecs[2]  = '{32'h40600000, 32'h00000004, 1'b0, 1'b1, 24, 1};
    vecs[3]  = '{32'h3F000000, 32'h00000000, 1'b0, 1'b1, 26, 0};
    vecs[4]  = '{32'h3F400000, 32'h00000001, 1'b0, 1'b1, 26, 2};
    vecs[5]  = '{32'hBFC00000, 32'hFFFFFFFE, 1'b0, 1'b1, 25, 0};
    vecs[6]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2, 0};
    vecs[7]  = '{32'hCF000000, 32'h80000000, 1'b0, 1'b0, 10, 0};
    vecs[8]  = '{32'h7FC00000, 32'h80000000, 1'b1, 1'b0, 2, 1};
    vecs[9]  = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0, 2, 0};
    vecs[10] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 2, 0};
    vecs[11] = '{32'h00000001, 32'h00000000, 1'b0, 1'b1, 35, 0};
    vecs[12] = '{32'h80000000, 32'h00000000, 1'b0, 1'b0, 35, 0};
    vecs[13] = '{32'h4B7FFFFF, 32'h00FFFFFF, 1'b0, 1'b0, 2, 0};
    vecs[14] = '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 9, 0};
    vecs[15] = '{32'hCF000001, 32'h80000000, 1'b1, 1'b0, 2, 0};
    vecs[16] = '{32'h00800000, 32'h00000000, 1'b0, 1'b1, 35, 0};
    vecs[17] = '{32'h3EFFFFFF, 32'h00000000, 1'b0, 1'b1, 27, 0};
    vecs[18] = '{32'h4B000001, 32'h00800001, 1'b0, 1'b0, 2, 0};
    vecs[19] = '{32'h3FC00000, 32'h00000002, 1'b0, 1'b1, 25, 0};
    vecs[20] = '{32'hC1200000, 32'hFFFFFFF6, 1'b0, 1'b0, 22, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_f      = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_i", out_i, 32'd0);
`ifdef FP_TO_INT32_FLAGS_EN
    check("reset_flags", {30'd0, flag_invalid, flag_inexact}, 32'd0);
`endif

    for (int i = 0; i < 21; i++) begin
      run_vec(vecs[i], i);
    end

    // Abort a conversion mid-shift with reset, then convert 10.0.
    in_valid = 1'b1;
    in_f     = 32'h3F800000;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_accepted", {31'd0, in_ready}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (30) @(negedge clk);
    check("abort_no_output", {31'd0, out_valid}, 32'd0);
    run_vec('{32'h41200000, 32'h0000000A, 1'b0, 1'b0, 22, 0}, 99);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_to_int32.md
Name: fp_to_int32

Overview:
- Multi-cycle converter from IEEE-754 single-precision bit patterns to signed 32-bit two's-complement integers.
- Rounding is round-to-nearest-even, matching fp_adder.
- Sits downstream of fp_adder and reads its packed results back into integer datapaths.
- Uses a ready/valid handshake on both sides and an iterative shifter sized by parameter.

Parameters:
- STEP, 1, bits shifted per cycle in SHIFT state; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_f holds a float to convert
- in_ready  output  1  converter idle, can accept
- in_f  input  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}
- out_valid  output  1  out_i valid; held until accepted
- out_ready  input  1  consumer accepts out_i
- out_i  output  32  signed integer result

Behaviour:
- Interface (already decided): single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_i=0, in_ready=1. Flags are 0 when present. Reset mid-operation aborts the conversion; no output is produced.
- FSM: IDLE -> SHIFT -> ROUND -> DONE -> IDLE.
- in_ready = (state==IDLE). Input is accepted on the edge where in_valid && in_ready.
- Accept: latch sign s, e, m = {e!=0, frac}. Working register W[63:0] = {8'b0, m, 32'b0}: integer part W[63:32], fraction W[31:0]. Set sticky=0.
- Classification at accept, using d = e - 150:
  - special (NaN/inf/overflow): e==255, or d > 7.
  - exception: e==158, frac==0, s==1 (exactly -2^31) is exact, not overflow.
  - shift direction: d >= 0 left-shifts by d; d < 0 right-shifts by min(-d, 33).
  - e==0 (zero/subnormal): treated as right shift 33, result 0.
- SHIFT: each cycle shift W by min(STEP, remaining) in the latched direction and decrement remaining by the same amount. On right shifts, OR every bit dropped below W[0] into sticky. When remaining==0 (including when it is 0 on entry), go to ROUND.
- ROUND (one cycle):
  - Rounding bits: G=W[31], R|S = |W[30:0] | sticky, L=W[32].
  - Magnitude = W[63:32] + (G & (L | R|S)).
  - Apply sign by two's-complement negation when s=1.
  - Saturation:
    - NaN -> 32'h80000000.
    - +inf or positive overflow -> 32'h7FFFFFFF.
    - -inf or negative overflow -> 32'h80000000.
    - Magnitude is never >= 2^31 after rounding for in-range inputs (24-bit mantissa).
  - Load out_i and set out_valid at the end of the cycle.
- DONE: out_valid=1 and out_i stable while out_ready=0. On out_valid && out_ready, go to IDLE; in_ready rises the next cycle. No same-cycle turnaround.
- Latency: accept edge to out_valid high = ceil(n/STEP) + 2 cycles.
  - n = left/right shift amount as above.
  - n = 0 for specials.
  - Throughput is one conversion per latency+1 cycles minimum.
- -0.0 converts to 0. in_f is don't-care outside the accept edge.

Optional Feature:
- Macro FP_TO_INT32_FLAGS_EN.
- Defined: adds outputs flag_invalid (1) and flag_inexact (1), registered with out_i and valid under the same handshake.
  - flag_invalid = NaN, inf, or overflow saturation.
  - flag_inexact = non-invalid and (G | R|S) != 0.
  - Exact -2^31 raises neither flag.
- Undefined: ports and logic are absent; out_i behaviour is identical.

Decomposition:
- Package fp_pkg: constants FP_EXP_W=8, FP_FRAC_W=23, FP_BIAS=127, INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000; typedef fp32_t (packed struct sign/exp/frac) shared with fp_adder; state enum for this FSM.
- One natural sub-module: fp_rne_round — combinational rounding, negation and saturation used in the ROUND state.

Test Plan:
- STEP=1, in_f=32'h3F800000 (1.0) -> out_i=1, out_valid exactly 25 cycles after accept; flag_inexact=0.
- Ties, converted in sequence:
  - 32'h40200000 (2.5) -> 2
  - 32'h40600000 (3.5) -> 4
  - 32'h3F000000 (0.5) -> 0
  - 32'h3F400000 (0.75) -> 1
  - 32'hBFC00000 (-1.5) -> 32'hFFFFFFFE
- Saturation and specials:
  - 32'h4F000000 -> 32'h7FFFFFFF, invalid=1
  - 32'hCF000000 -> 32'h80000000, invalid=0
  - 32'h7FC00000 (NaN) -> 32'h80000000
  - 32'hFF800000 (-inf) -> 32'h80000000
  - Each special has latency 2.
- Subnormal/zero: 32'h00000001 -> 0 (inexact=1); 32'h80000000 -> 0 (inexact=0); 32'h4B7FFFFF -> 16777215.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_i stable, in_ready=0 throughout; in_ready=1 the cycle after the handshake.
- Assert rst during SHIFT for 32'h3F800000 -> next cycle out_valid=0, in_ready=1; a new 32'h41200000 (10.0) then converts to 10.
